// File: rtl/sd_bd_fifo_if.sv
// sd_bd_fifo_if: request/response signals between the BD queue and its two clients.
// The register slave writes BD words and the DMA engine reads them.
// The master modport drives requests into the queue.
// The slave modport is the queue's own view of the same signals.
interface sd_bd_fifo_if #(
  parameter int WORD_W = 32
);
  logic              flush;
  logic              we_m;
  logic [WORD_W-1:0] dat_in_m;
  logic              re_s;
  logic [WORD_W-1:0] dat_out_s;
  logic              ack_s;
  logic              bd_avail;
  logic [7:0]        free_bd;
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output flush, we_m, dat_in_m, re_s, ovf_clr,
    input  dat_out_s, ack_s, bd_avail, free_bd, ovf
  );

  modport slave (
    input  flush, we_m, dat_in_m, re_s, ovf_clr,
    output dat_out_s, ack_s, bd_avail, free_bd, ovf
  );
endinterface

// File: rtl/sd_bd_fifo.sv
// sd_bd_fifo: buffer-descriptor queue between the SD register slave and the DMA engine.
// Each BD is two words: word 0 is the card block address, word 1 is the system buffer address.
// A BD becomes visible to the reader only after both of its words are written.
// Its slot is freed only after both of its words are read.
// Optional feature: define SD_BD_OVF_STICKY_EN to make ovf a sticky flag that ovf_clr clears.
// Without that macro, ovf is a one-cycle pulse for each dropped word.
module sd_bd_fifo #(
  parameter int BD_SIZE = 8,
  parameter int BD_AW   = 3,
  parameter int WORD_W  = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  sd_bd_fifo_if.slave bus
);

  localparam int              NWORDS   = 2 * BD_SIZE;
  localparam logic [BD_AW:0]  CNT_ONE  = (BD_AW + 1)'(1);
  localparam logic [BD_AW:0]  CNT_FULL = (BD_AW + 1)'(BD_SIZE);

  logic [WORD_W-1:0] mem_q [NWORDS];

  logic [BD_AW:0]    wr_ptr_q, wr_ptr_d;
  logic [BD_AW:0]    rd_ptr_q, rd_ptr_d;
  logic              wr_half_q, wr_half_d;
  logic              rd_half_q, rd_half_d;
  logic [BD_AW:0]    free_q, free_d;
  // Number of complete BDs that the reader has not started yet.
  logic [BD_AW:0]    ready_q, ready_d;
  logic              bd_avail_q, bd_avail_d;
  logic              ack_q, ack_d;
  logic [WORD_W-1:0] dat_out_q, dat_out_d;
  logic              ovf_q, ovf_d;

  logic              wr_acc, rd_acc, ovf_evt;
  logic              bd_done, bd_rel, bd_start;

  // Classify this cycle's requests. Flush masks both writes and reads.
  always_comb begin
    wr_acc   = bus.we_m && (free_q != '0) && !bus.flush;
    ovf_evt  = bus.we_m && (free_q == '0) && !wr_half_q && !bus.flush;
    rd_acc   = bus.re_s && (bd_avail_q || rd_half_q) && !bus.flush;
    bd_done  = wr_acc && wr_half_q;
    bd_rel   = rd_acc && rd_half_q;
    bd_start = rd_acc && !rd_half_q;
  end

  // Next-state for pointers, half flags, BD counters and the read port.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_half_d = wr_half_q;
    rd_half_d = rd_half_q;
    free_d    = free_q;
    ready_d   = ready_q;
    ack_d     = 1'b0;
    dat_out_d = dat_out_q;

    if (wr_acc) begin
      wr_ptr_d  = wr_ptr_q + CNT_ONE;
      wr_half_d = !wr_half_q;
    end

    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + CNT_ONE;
      rd_half_d = !rd_half_q;
      ack_d     = 1'b1;
      dat_out_d = mem_q[rd_ptr_q];
    end

    // If one BD completes and another is released in the same cycle, the free count stays the same.
    case ({bd_done, bd_rel})
      2'b10:   free_d = free_q - CNT_ONE;
      2'b01:   free_d = free_q + CNT_ONE;
      default: free_d = free_q;
    endcase

    case ({bd_done, bd_start})
      2'b10:   ready_d = ready_q + CNT_ONE;
      2'b01:   ready_d = ready_q - CNT_ONE;
      default: ready_d = ready_q;
    endcase

    bd_avail_d = (ready_d != '0);
  end

  // Overflow flag next state. The dropped word never reaches storage.
  always_comb begin
`ifdef SD_BD_OVF_STICKY_EN
    // An overflow in the same cycle as ovf_clr takes precedence, so the flag is set.
    ovf_d = ovf_q;
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
`else
    ovf_d = ovf_evt;
`endif
  end

  // Control and read-port registers. Flush returns them to the reset state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_half_q  <= 1'b0;
      rd_half_q  <= 1'b0;
      free_q     <= CNT_FULL;
      ready_q    <= '0;
      bd_avail_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_out_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_half_q  <= 1'b0;
      rd_half_q  <= 1'b0;
      free_q     <= CNT_FULL;
      ready_q    <= '0;
      bd_avail_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_out_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_half_q  <= wr_half_d;
      rd_half_q  <= rd_half_d;
      free_q     <= free_d;
      ready_q    <= ready_d;
      bd_avail_q <= bd_avail_d;
      ack_q      <= ack_d;
      dat_out_q  <= dat_out_d;
    end
  end

  // Overflow register. Only reset clears it; flush does not.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // BD word storage. Its contents are not reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.dat_in_m;
    end
  end

  assign bus.dat_out_s = dat_out_q;
  assign bus.ack_s     = ack_q;
  assign bus.bd_avail  = bd_avail_q;
  assign bus.free_bd   = 8'(free_q);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sd_bd_fifo.sv
// tb_sd_bd_fifo: directed scenarios plus randomized traffic for sd_bd_fifo.
// A word-queue reference model predicts every output on each cycle.
// Literal expectations in the directed scenarios pin that model.
module tb_sd_bd_fifo;
  localparam int BD_SIZE = 8;
  localparam int BD_AW   = 3;
  localparam int WORD_W  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sd_bd_fifo_if #(.WORD_W(WORD_W)) bus ();

  sd_bd_fifo #(.BD_SIZE(BD_SIZE), .BD_AW(BD_AW), .WORD_W(WORD_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: queued words plus counts of held and ready BDs.
  logic [31:0] mq [$];
  int          m_held  = 0;
  int          m_ready = 0;
  bit          m_wh    = 1'b0;
  bit          m_rh    = 1'b0;
  int          e_free  = BD_SIZE;
  bit          e_avail = 1'b0;
  bit          e_ack   = 1'b0;
  logic [31:0] e_dat   = '0;
  bit          e_ovf   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_held  = 0;
    m_ready = 0;
    m_wh    = 1'b0;
    m_rh    = 1'b0;
    e_free  = BD_SIZE;
    e_avail = 1'b0;
    e_ack   = 1'b0;
    e_dat   = '0;
    e_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic fl, input logic we, input logic [31:0] d, input logic re);
    bit acc_w;
    bit acc_r;
    bit ovfe;
    acc_w = 1'b0;
    acc_r = 1'b0;
    ovfe  = 1'b0;
    if (fl) begin
      mq.delete();
      m_held  = 0;
      m_ready = 0;
      m_wh    = 1'b0;
      m_rh    = 1'b0;
      e_ack   = 1'b0;
      e_dat   = '0;
    end else begin
      acc_w = we && (e_free > 0);
      ovfe  = we && (e_free == 0) && !m_wh;
      acc_r = re && (e_avail || m_rh);
      e_ack = acc_r;
      if (acc_r) begin
        e_dat = mq.pop_front();
        if (m_rh) begin
          m_rh = 1'b0;
          m_held--;
        end else begin
          m_rh = 1'b1;
          m_ready--;
        end
      end
      if (acc_w) begin
        mq.push_back(d);
        if (m_wh) begin
          m_wh = 1'b0;
          m_held++;
          m_ready++;
        end else begin
          m_wh = 1'b1;
        end
      end
    end
    e_free  = BD_SIZE - m_held;
    e_avail = (m_ready > 0);
`ifdef SD_BD_OVF_STICKY_EN
    if (ovfe) e_ovf = 1'b1;
    else if (bus.ovf_clr) e_ovf = 1'b0;
`else
    e_ovf = ovfe;
`endif
  endtask

  // Advance the model on every clock edge and apply reset asynchronously, as the DUT does.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(bus.flush, bus.we_m, bus.dat_in_m, bus.re_s);
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ack_s",     32'(bus.ack_s),    32'(e_ack));
        check("dat_out_s", bus.dat_out_s,     e_dat);
        check("bd_avail",  32'(bus.bd_avail), 32'(e_avail));
        check("free_bd",   32'(bus.free_bd),  32'(e_free));
        check("ovf",       32'(bus.ovf),      32'(e_ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.flush    = 1'b0;
    bus.we_m     = 1'b0;
    bus.dat_in_m = '0;
    bus.re_s     = 1'b0;
    bus.ovf_clr  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.we_m     = 1'b1;
    bus.dat_in_m = d;
    tick();
    bus.we_m     = 1'b0;
  endtask

  task automatic rd();
    bus.re_s = 1'b1;
    tick();
    bus.re_s = 1'b0;
  endtask

  logic [31:0] words [16];
  logic [31:0] prev0, prev1, cur0, cur1;

  initial begin
    idle();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_free",  32'(bus.free_bd),  32'd8);
    check("rst_avail", 32'(bus.bd_avail), 32'd0);
    check("rst_ack",   32'(bus.ack_s),    32'd0);
    check("rst_ovf",   32'(bus.ovf),      32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // Single BD round trip.
    wr(32'h0000_1000);
    wr(32'h8000_0000);
    check("bd1_free",  32'(bus.free_bd),  32'd7);
    check("bd1_avail", 32'(bus.bd_avail), 32'd1);
    rd();
    check("bd1_ack0",   32'(bus.ack_s),    32'd1);
    check("bd1_dat0",   bus.dat_out_s,     32'h0000_1000);
    check("bd1_avail0", 32'(bus.bd_avail), 32'd0);
    rd();
    check("bd1_dat1",   bus.dat_out_s,     32'h8000_0000);
    check("bd1_free2",  32'(bus.free_bd),  32'd8);
    tick();
    check("bd1_ackoff", 32'(bus.ack_s),    32'd0);

    // A half-written BD stays hidden from the reader.
    wr(32'h0000_ABCD);
    rd();
    check("half_ack",   32'(bus.ack_s),    32'd0);
    check("half_avail", 32'(bus.bd_avail), 32'd0);
    check("half_free",  32'(bus.free_bd),  32'd8);
    wr(32'h0000_1234);
    rd();
    rd();
    tick();

    // Fill the queue, then write one more word so that it overflows.
    for (int i = 0; i < 16; i++) begin
      words[i] = {16'hA5A5, 16'(i)};
      wr(words[i]);
    end
    check("fill_free", 32'(bus.free_bd), 32'd0);
    wr(32'h0000_DEAD);
    check("ovf_set", 32'(bus.ovf), 32'd1);
    tick();
`ifdef SD_BD_OVF_STICKY_EN
    check("ovf_hold", 32'(bus.ovf), 32'd1);
`else
    check("ovf_pulse", 32'(bus.ovf), 32'd0);
`endif
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.ovf), 32'd0);
    bus.re_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("fill_order", bus.dat_out_s, words[i]);
    end
    bus.re_s = 1'b0;
    tick();
    check("drain_free", 32'(bus.free_bd), 32'd8);

    // Wrap: each BD completes in the same cycle that the previous BD is released.
    prev0 = 32'h0B00_0000;
    prev1 = 32'h0B00_0001;
    wr(prev0);
    wr(prev1);
    bus.re_s = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cur0 = {16'h0B00, 8'(k), 8'h00};
      cur1 = {16'h0B00, 8'(k), 8'h01};
      bus.we_m     = 1'b1;
      bus.dat_in_m = cur0;
      tick();
      check("wrap_w0", bus.dat_out_s, prev0);
      bus.dat_in_m = cur1;
      tick();
      check("wrap_w1",   bus.dat_out_s,    prev1);
      check("wrap_free", 32'(bus.free_bd), 32'd7);
      prev0 = cur0;
      prev1 = cur1;
    end
    bus.we_m = 1'b0;
    tick();
    check("wrap_last0", bus.dat_out_s, prev0);
    tick();
    check("wrap_last1", bus.dat_out_s, prev1);
    bus.re_s = 1'b0;
    tick();

    // Flush while a write is requested: the flush wins and the word is discarded.
    for (int i = 0; i < 6; i++) wr(32'h0F00_0000 + 32'(i));
    bus.flush    = 1'b1;
    bus.we_m     = 1'b1;
    bus.dat_in_m = 32'h0000_F1F1;
    tick();
    idle();
    check("flush_free",  32'(bus.free_bd),  32'd8);
    check("flush_avail", 32'(bus.bd_avail), 32'd0);
    wr(32'h0000_0011);
    wr(32'h0000_0022);
    rd();
    check("flush_dat", bus.dat_out_s, 32'h0000_0011);
    rd();
    tick();

    // Reset in the middle of a BD discards the half-written BD.
    wr(32'h0000_0055);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr(32'h0000_0066);
    wr(32'h0000_0077);
    rd();
    check("midrst_dat", bus.dat_out_s, 32'h0000_0066);
    rd();
    tick();

    // Randomized traffic checked against the model.
    for (int n = 0; n < 1500; n++) begin
      bus.we_m     = ($urandom_range(99) < 55);
      bus.re_s     = ($urandom_range(99) < 45);
      bus.flush    = ($urandom_range(199) < 2);
      bus.ovf_clr  = ($urandom_range(99) < 5);
      bus.dat_in_m = $urandom;
      tick();
    end
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
